alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, multi-cycle successor to the 8-bit Ahmes combinational ALU. It keeps the Ahmes opcode map and flag set (N, Z, C, B, V) and adds:
- operand width `W`;
- registered results and flags;
- valid/ready handshakes on input and output;
- multi-bit shifts and rotates executed one bit per cycle;
- ADC/SBB;
- an optional iterative unsigned multiplier.

It sits between the control unit and the accumulator/flag registers of the datapath.

## Interface
Parameters:
- `W`, 8, operand/result width; W ≥ 4, power of two.
- `CW`, $clog2(W)+1, shift-count width, taken from `b[CW-1:0]`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  block can accept; transfer occurs when `in_valid && in_ready`.
- `op`  in  4  opcode.
- `a`  in  W  operand A.
- `b`  in  W  operand B; low `CW` bits give the shift/rotate count.
- `cin`  in  1  carry in.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer takes result; transfer occurs when `out_valid && out_ready`.
- `result`  out  W  result.
- `result_hi`  out  W  upper product half (MUL only; otherwise 0).
- `flag_n`, `flag_z`, `flag_c`, `flag_b`, `flag_v`  out  1 each  negative, zero, carry, borrow, overflow.

## Operation
Opcodes:
- 0001 ADD
- 0010 SUB
- 0011 OR
- 0100 AND
- 0101 NOT (~a)
- 0110 XOR
- 0111 ROL
- 1000 ROR
- 1001 SHL
- 1010 SHR
- 1011 ADC
- 1100 SBB
- 1101 MUL
- all others undefined

Arithmetic rules:
- ADD/ADC: `{c, result} = a + b (+ cin for ADC)`, computed at W+1 bits. `flag_b = 0`. `flag_v = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1])`.
- SUB/SBB: `{borrow, result} = a − b (− cin for SBB)`, computed at W+1 bits. `flag_b = borrow`. `flag_c = 0`. `flag_v = (a[W-1] != b[W-1]) && (result[W-1] != a[W-1])`.
- Logic ops: `flag_c`, `flag_b`, `flag_v` are 0.

Shifts and rotates:
- Count `k = b[CW-1:0]`; k is saturated to W for SHL/SHR.
- Each step uses the previous step's C. The first step uses `cin` for ROL/ROR and 0 for SHL/SHR.
- ROL step: `C ← msb`, `r ← {r[W-2:0], C_prev}`.
- ROR step: `C ← lsb`, `r ← {C_prev, r[W-1:1]}`.
- SHL: shifts in 0, `C ← msb`.
- SHR: shifts in 0, `C ← lsb`.
- ROL/ROR therefore rotate through carry over W+1 bits.
- k = 0: `result = a`, `flag_c = 0`.

MUL:
- Unsigned shift-add, one bit of b per cycle.
- `{result_hi, result} = a × b`.
- `flag_c = flag_v = |result_hi`.

Common flags:
- `flag_n = result[W-1]` and `flag_z = (result == 0)`, evaluated on the final `result` (low half for MUL).
- Undefined opcode: `result = 0`, so `flag_z = 1`; all other flags are 0.

State machine:
- IDLE: `in_ready = 1`. On transfer:
  - single-cycle ops → DONE;
  - shift/rotate with k > 0 → SHIFT;
  - MUL → MULT.
- SHIFT: one step per cycle, k steps, then → DONE.
- MULT: W cycles, then → DONE.
- DONE: `out_valid = 1`.
  - On output transfer: → IDLE, or directly into the next op if an input transfer occurs in the same cycle.
  - `in_ready = out_ready` in this state.
- `in_ready` is 0 in SHIFT and MULT.
- Operands are captured at accept. Later changes on `a`, `b`, `op`, `cin` have no effect.

## Timing
Reset values (applies whenever `rst` is sampled high):
- `state = IDLE`, `out_valid = 0`.
- `result = 0`, `result_hi = 0`, all flags 0.
- `in_ready = 0` during the reset cycle.

Reset overrides everything:
- Reset mid-SHIFT/MULT aborts the op with no output.
- Reset in DONE drops the pending result.

Latency, from the accept edge t:
- Single-cycle ops and k = 0: `out_valid` at t+1.
- Shift/rotate: t+1+k.
- MUL: t+1+W.

Handshake:
- Outputs hold stable while `out_valid && !out_ready`.
- Single-cycle ops sustain one op per cycle while `out_ready` is held high.

## Configuration
- `ALU_SEQ_MUL_EN` defined: MULT state and multiplier are compiled in; opcode 1101 behaves as MUL.
- `ALU_SEQ_MUL_EN` undefined: 1101 is an undefined opcode (1-cycle latency, `result = 0`, `flag_z = 1`). `result_hi` is tied to 0 and no multiplier logic is generated.

## Test plan
All scenarios use W = 8.
- ADD `a = 0x7F`, `b = 0x01` → at t+1: `result = 0x80`, n = 1, v = 1, c = 0, z = 0. ADC `0xFF + 0x00`, `cin = 1` → `0x00`, c = 1, z = 1.
- SUB `a = 0x00`, `b = 0x01` → `0xFF`, b = 1, n = 1, v = 0. SUB `0x80 − 0x01` → `0x7F`, v = 1.
- SHL `a = 0x81`, k = 3 → at t+4: `0x08`, c = 0. ROL `a = 0x80`, `cin = 0`, k = 1 → `0x00`, c = 1, z = 1. k = 0 → `result = a` at t+1.
- MUL `0x10 × 0x10` → at t+9: `result = 0x00`, `result_hi = 0x01`, c = v = 1, z = 1. Build without `ALU_SEQ_MUL_EN` → at t+1: `result = 0`, z = 1.
- Back-pressure: hold `out_ready = 0` for 5 cycles → outputs stable and `in_ready = 0`. Then raise `out_ready` with `in_valid` → next op accepted in the same cycle. Back-to-back ADDs give one result per cycle.
- Assert `rst` during cycle 3 of SHIFT with k = 6 → next cycle: IDLE, `out_valid = 0`, outputs 0. No stale result ever appears.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle Ahmes-compatible ALU with valid/ready handshakes and serial shifts.
// Optional iterative unsigned multiplier enabled by defining ALU_SEQ_MUL_EN.
module alu_seq #(
    parameter int W  = 8,
    parameter int CW = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [W-1:0] result_hi,
    output logic         flag_n,
    output logic         flag_z,
    output logic         flag_c,
    output logic         flag_b,
    output logic         flag_v
);
    localparam logic [3:0] OP_ADD = 4'd1, OP_SUB = 4'd2, OP_OR = 4'd3, OP_AND = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5, OP_XOR = 4'd6, OP_ROL = 4'd7, OP_ROR = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9, OP_SHR = 4'd10, OP_ADC = 4'd11, OP_SBB = 4'd12;
    localparam logic [3:0] OP_MUL = 4'd13;

    typedef enum logic [1:0] {IDLE, SHIFT, MULT, DONE} state_t;

    state_t         state_q, state_d;
    logic [3:0]     op_q, op_d;
    logic [W-1:0]   r_q, r_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           n_q, n_d, z_q, z_d, c_q, c_d, bw_q, bw_d, v_q, v_d;
    logic [W:0]     sum;
    logic [CW-1:0]  k;
    logic           accept, rot, left, fill;
`ifdef ALU_SEQ_MUL_EN
    logic [W-1:0]   hi_q, hi_d, m_q, m_d;
    logic [W:0]     psum;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        z_d       = z_q;
        c_d       = c_q;
        bw_d      = bw_q;
        v_d       = v_q;
        sum       = '0;
        k         = b[CW-1:0];
`ifdef ALU_SEQ_MUL_EN
        hi_d      = hi_q;
        m_d       = m_q;
        psum      = '0;
`endif
        in_ready  = !rst && (state_q == IDLE || (state_q == DONE && out_ready));
        out_valid = !rst && state_q == DONE;
        accept    = in_valid && in_ready;
        rot       = op_q == OP_ROL || op_q == OP_ROR;
        left      = op_q == OP_ROL || op_q == OP_SHL;
        fill      = rot & c_q;
        if (state_q == DONE && out_ready)
            state_d = IDLE;
        // c_q doubles as the running carry, so rotates go through W+1 bits
        if (state_q == SHIFT) begin
            c_d   = left ? r_q[W-1] : r_q[0];
            r_d   = left ? {r_q[W-2:0], fill} : {fill, r_q[W-1:1]};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1))
                state_d = DONE;
        end
`ifdef ALU_SEQ_MUL_EN
        // r_q holds the unconsumed multiplier bits and fills with product low bits
        if (state_q == MULT) begin
            psum         = {1'b0, hi_q} + {1'b0, m_q & {W{r_q[0]}}};
            {hi_d, r_d}  = {psum, r_q[W-1:1]};
            cnt_d        = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                state_d = DONE;
                c_d     = |psum[W:1];
                v_d     = |psum[W:1];
            end
        end
`endif
        if (accept) begin
            op_d    = op;
            r_d     = '0;
            c_d     = 1'b0;
            bw_d    = 1'b0;
            v_d     = 1'b0;
            state_d = DONE;
`ifdef ALU_SEQ_MUL_EN
            hi_d    = '0;
`endif
            case (op)
                OP_ADD, OP_ADC: begin
                    sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, (op == OP_ADC) & cin};
                    r_d = sum[W-1:0];
                    c_d = sum[W];
                    v_d = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
                end
                OP_SUB, OP_SBB: begin
                    sum  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, (op == OP_SBB) & cin};
                    r_d  = sum[W-1:0];
                    bw_d = sum[W];
                    v_d  = (a[W-1] != b[W-1]) && (sum[W-1] != a[W-1]);
                end
                OP_OR:  r_d = a | b;
                OP_AND: r_d = a & b;
                OP_NOT: r_d = ~a;
                OP_XOR: r_d = a ^ b;
                OP_ROL, OP_ROR, OP_SHL, OP_SHR: begin
                    if ((op == OP_SHL || op == OP_SHR) && k > CW'(W))
                        k = CW'(W);
                    r_d   = a;
                    cnt_d = k;
                    if (k != '0) begin
                        state_d = SHIFT;
                        c_d     = (op == OP_ROL || op == OP_ROR) & cin;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                OP_MUL: begin
                    r_d     = b;
                    m_d     = a;
                    cnt_d   = CW'(W);
                    state_d = MULT;
                end
`endif
                default: ;
            endcase
        end
        if (state_d == DONE) begin
            n_d = r_d[W-1];
            z_d = ~|r_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            bw_q    <= 1'b0;
            v_q     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            hi_q    <= '0;
            m_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            bw_q    <= bw_d;
            v_q     <= v_d;
`ifdef ALU_SEQ_MUL_EN
            hi_q    <= hi_d;
            m_q     <= m_d;
`endif
        end
    end

    assign result = r_q;
`ifdef ALU_SEQ_MUL_EN
    assign result_hi = hi_q;
`else
    assign result_hi = '0;
`endif
    assign flag_n = n_q;
    assign flag_z = z_q;
    assign flag_c = c_q;
    assign flag_b = bw_q;
    assign flag_v = v_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq (W=8) checked against an arithmetic reference model.
// Expected MUL behaviour follows whether ALU_SEQ_MUL_EN is defined for the build.
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, flag_n, flag_z, flag_c, flag_b, flag_v;
    logic [W-1:0] result, result_hi;

    alu_seq #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .result_hi(result_hi), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
        .flag_b(flag_b), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r, hi;
        logic       n, z, c, bf, v;
        int         lat, due;
        bit         seen;
    } exp_t;

    int   checks = 0, errors = 0, cyc = 0;
    exp_t q[$];
    exp_t ne;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                   input logic ci);
        exp_t        e;
        int          s, k, ks;
        logic [8:0]  v9;
        logic [15:0] t;
        e.r = 0; e.hi = 0; e.c = 0; e.bf = 0; e.v = 0; e.lat = 1; e.due = 0; e.seen = 0;
        k  = int'(y[3:0]);
        ks = (k > 8) ? 8 : k;
        case (o)
            4'd1, 4'd11: begin
                s = int'(x) + int'(y) + ((o == 4'd11) ? int'(ci) : 0);
                e.r = 8'(s); e.c = s > 255;
                e.v = (x[7] == y[7]) && (e.r[7] != x[7]);
            end
            4'd2, 4'd12: begin
                s = int'(x) - int'(y) - ((o == 4'd12) ? int'(ci) : 0);
                e.r = 8'(s); e.bf = s < 0;
                e.v = (x[7] != y[7]) && (e.r[7] != x[7]);
            end
            4'd3: e.r = x | y;
            4'd4: e.r = x & y;
            4'd5: e.r = ~x;
            4'd6: e.r = x ^ y;
            4'd7, 4'd8: begin
                e.r = x;
                if (k != 0) begin
                    v9 = {ci, x};
                    for (int i = 0; i < k; i++)
                        v9 = (o == 4'd7) ? {v9[7:0], v9[8]} : {v9[0], v9[8:1]};
                    e.r = v9[7:0]; e.c = v9[8]; e.lat = 1 + k;
                end
            end
            4'd9: begin
                t = {8'h00, x} << ks;
                e.r = t[7:0]; e.c = (ks > 0) && t[8]; e.lat = 1 + ks;
            end
            4'd10: begin
                t = {x, 8'h00} >> ks;
                e.r = t[15:8]; e.c = (ks > 0) && t[7]; e.lat = 1 + ks;
            end
`ifdef ALU_SEQ_MUL_EN
            4'd13: begin
                t = {8'h00, x} * {8'h00, y};
                e.r = t[7:0]; e.hi = t[15:8]; e.c = |t[15:8]; e.v = |t[15:8]; e.lat = 1 + W;
            end
`endif
            default: ;
        endcase
        e.n = e.r[7];
        e.z = e.r == 0;
        return e;
    endfunction

    // scoreboard: one entry per accepted op, compared whenever out_valid is high
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 0);
                end else begin
                    chk("result", result, q[0].r);
                    chk("result_hi", result_hi, q[0].hi);
                    chk("flags_nzcbv", {flag_n, flag_z, flag_c, flag_b, flag_v},
                        {q[0].n, q[0].z, q[0].c, q[0].bf, q[0].v});
                    chk("in_ready_in_done", in_ready, out_ready);
                    if (!q[0].seen) begin
                        chk("latency", cyc, q[0].due);
                        q[0].seen = 1;
                    end
                    if (out_ready) void'(q.pop_front());
                end
            end else if (q.size() > 0 && cyc >= q[0].due) begin
                chk("out_valid_when_due", out_valid, 1);
                void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                ne = model(op, a, b, cin);
                ne.due = cyc + ne.lat;
                q.push_back(ne);
            end
        end
    end

    task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, output int tacc);
        @(posedge clk); #1;
        op = o; a = x; b = y; cin = ci; in_valid = 1'b1;
        tacc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                tacc = cyc;
                break;
            end
        end
        if (tacc < 0) chk("accept_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~x; b = ~y; op = 4'hF; cin = ~ci;
    endtask

    task automatic wait_out(output int tout);
        tout = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) begin
                tout = cyc;
                break;
            end
        end
        if (tout < 0) chk("out_timeout", out_valid, 1);
    endtask

    task automatic lit(input string nm, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic ci, input logic [7:0] er, input logic [7:0] eh,
                       input logic [4:0] ef, input int elat);
        int ta, to;
        send(o, x, y, ci, ta);
        wait_out(to);
        chk({nm, "_result"}, result, er);
        chk({nm, "_hi"}, result_hi, eh);
        chk({nm, "_nzcbv"}, {flag_n, flag_z, flag_c, flag_b, flag_v}, ef);
        chk({nm, "_latency"}, to - ta, elat);
    endtask

    logic [3:0] vop[13] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd10, 4'd9, 4'd8, 4'd12, 4'd11, 4'd0, 4'd14, 4'd13};
    logic [7:0] va[13]  = '{8'hF0, 8'hF0, 8'h00, 8'h5A, 8'h01, 8'h81, 8'hC3, 8'h96, 8'h10, 8'h7F, 8'h55, 8'h12, 8'hFF};
    logic [7:0] vb[13]  = '{8'h0F, 8'h3C, 8'h00, 8'h5A, 8'h02, 8'h01, 8'h0F, 8'h09, 8'h05, 8'h00, 8'hAA, 8'h34, 8'hFF};
    logic       vc[13]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int ta, to;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_hi", result_hi, 0);
        chk("rst_flags", {flag_n, flag_z, flag_c, flag_b, flag_v}, 0);
        chk("idle_in_ready", in_ready, 1);

        lit("add", 4'd1, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 5'b10001, 1);
        lit("adc", 4'd11, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 5'b01100, 1);
        lit("sub0", 4'd2, 8'h00, 8'h01, 1'b0, 8'hFF, 8'h00, 5'b10010, 1);
        lit("sub1", 4'd2, 8'h80, 8'h01, 1'b0, 8'h7F, 8'h00, 5'b00001, 1);
        lit("shl3", 4'd9, 8'h81, 8'h03, 1'b0, 8'h08, 8'h00, 5'b00000, 4);
        lit("rol1", 4'd7, 8'h80, 8'h01, 1'b0, 8'h00, 8'h00, 5'b01100, 2);
        lit("rol0", 4'd7, 8'hA5, 8'h00, 1'b1, 8'hA5, 8'h00, 5'b10000, 1);
`ifdef ALU_SEQ_MUL_EN
        lit("mul", 4'd13, 8'h10, 8'h10, 1'b0, 8'h00, 8'h01, 5'b01101, 9);
`else
        lit("mul_off", 4'd13, 8'h10, 8'h10, 1'b0, 8'h00, 8'h00, 5'b01000, 1);
`endif

        for (int i = 0; i < 13; i++) begin
            send(vop[i], va[i], vb[i], vc[i], ta);
            wait_out(to);
        end

        // back-pressure, then a same-cycle release and new accept
        @(posedge clk); #1 out_ready = 1'b0;
        send(4'd1, 8'h12, 8'h34, 1'b0, ta);
        wait_out(to);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_result", result, 8'h46);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; op = 4'd6; a = 8'hFF; b = 8'h0F; cin = 1'b0;
        @(negedge clk);
        chk("release_accept", in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("release_result", result, 8'hF0);

        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; op = 4'd1; a = 8'(i * 37); b = 8'(i + 200); cin = 1'b1;
            @(negedge clk);
            chk("b2b_in_ready", in_ready, 1);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // reset in the third SHIFT cycle of a k=6 rotate
        send(4'd7, 8'h3C, 8'h06, 1'b1, ta);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_hi", result_hi, 0);
        chk("midrst_flags", {flag_n, flag_z, flag_c, flag_b, flag_v}, 0);
        repeat (12) @(negedge clk);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
